blaster_cmd_decoder: RTL and testbench
======================================

BLASTER_CMD_DECODER -- requirements
Module: blaster_cmd_decoder

Interface
REQ-001 SHALL have parameter TCK_HALF, default 4, meaning clock cycles per TCK half-period (legal range 1..255).
REQ-002 SHALL have port i_Clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port i_rdy, input, 1 bit: one-cycle strobe marking a received byte from the UART receiver.
REQ-005 SHALL have port i_byte, input, 8 bits: the received byte, valid when i_rdy=1.
REQ-006 SHALL have port i_tdo, input, 1 bit: asynchronous JTAG TDO.
REQ-007 SHALL have ports o_tck, o_tms and o_tdi, each output, 1 bit: the JTAG drive pins.
REQ-008 SHALL have port o_tx_valid, output, 1 bit: a response byte is pending.
REQ-009 SHALL have port o_tx_byte, output, 8 bits: the response byte.
REQ-010 SHALL have port i_tx_ready, input, 1 bit: the transmitter accepts o_tx_byte when i_tx_ready and o_tx_valid are both 1.
REQ-011 SHALL have port o_busy, output, 1 bit: 1 in the SHIFT_LOW and SHIFT_HIGH states.
REQ-012 SHALL have port o_err, output, 1 bit: one-cycle pulse when a byte or response is dropped.

Function
REQ-013 SHALL synchronise i_tdo through 2 flops; "TDO" below is the synchroniser output.
REQ-014 SHALL implement the states IDLE, SHIFT_WAIT, SHIFT_LOW and SHIFT_HIGH.
REQ-015 SHALL, in IDLE, decode i_byte[7]=0 on i_rdy as bit-bang: on the next cycle o_tck=b0, o_tms=b1, o_tdi=b4; state stays IDLE.
REQ-016 SHALL, for a bit-bang byte with b6=1, capture TDO on the accept cycle and queue response {7'b0, TDO}.
REQ-017 SHALL, in IDLE, decode i_byte[7]=1 on i_rdy as a shift header with count N=b[5:0] and read flag R=b6.
REQ-018 SHALL treat N=0 as a no-op (stay in IDLE); for N>0 it SHALL load remaining=N and latch R, then go to SHIFT_WAIT.
REQ-019 SHALL, in SHIFT_WAIT, take the next i_rdy byte as data, load the shift register and enter SHIFT_LOW with bit index 0, without decoding the byte as a command.
REQ-020 SHALL, in SHIFT_LOW: o_tck=0; o_tdi=data[idx]; hold for TCK_HALF cycles; sample TDO into cap[idx] on the last cycle; then go to SHIFT_HIGH.
REQ-021 SHALL, in SHIFT_HIGH: o_tck=1 for TCK_HALF cycles.
REQ-022 SHALL, at the end of SHIFT_HIGH, go to SHIFT_LOW with idx+1 if idx<7.
REQ-023 SHALL, at the end of SHIFT_HIGH with idx=7: drive o_tck=0; queue cap if R=1; decrement remaining; go to SHIFT_WAIT if remaining is nonzero, else IDLE.
REQ-024 SHALL shift bits LSB first, so one data byte takes exactly 16*TCK_HALF cycles.
REQ-025 SHALL keep o_tms unchanged for the whole shift sequence.
REQ-026 SHALL drop any i_rdy arriving in SHIFT_LOW or SHIFT_HIGH and pulse o_err; remaining is unchanged.
REQ-027 SHALL, when queueing a response: set o_tx_valid=1 and o_tx_byte=value on the next cycle, and hold both until the handshake completes.
REQ-028 SHALL clear o_tx_valid on the cycle after the handshake (o_tx_valid=1 and i_tx_ready=1).
REQ-029 SHALL, when a response is queued while o_tx_valid=1 and no handshake occurs in that cycle, keep the old byte, discard the new one and pulse o_err.
REQ-030 SHALL, when a response is queued in the same cycle that the handshake completes, load the new byte and keep o_tx_valid=1.
REQ-031 SHALL use a 6-bit remaining counter, a 3-bit bit index, and a cycle counter of width ceil(log2(TCK_HALF+1)).

Reset
REQ-032 SHALL, while reset=1 (asynchronously): state=IDLE; o_tck=o_tms=o_tdi=0; o_tx_valid=0; o_tx_byte=0; o_busy=0; o_err=0; remaining=0; synchroniser=0; cap=0.
REQ-033 SHALL abort any shift on reset mid-operation, with no response and no o_err, and resume IDLE decoding on the first cycle after reset falls.

Verification
REQ-034 SHALL be verified with: bit-bang 0x13 -> o_tck=1, o_tms=1, o_tdi=1 next cycle; no response.
REQ-035 SHALL be verified with: bit-bang 0x40 while TDO=1 -> o_tx_byte=0x01, o_tx_valid held until i_tx_ready=1.
REQ-036 SHALL be verified with: header 0xC1, data 0xA5, TDO looping TDI, TCK_HALF=4 -> 8 TCK pulses; TDI sequence 1,0,1,0,0,1,0,1; response 0xA5 64 cycles after data accept.
REQ-037 SHALL be verified with: header 0x82 then 2 data bytes -> 16 TCK pulses, no response, and return to IDLE.
REQ-038 SHALL be verified with: i_rdy during SHIFT_HIGH -> o_err pulse, byte ignored; also a second response with i_tx_ready=0 -> o_err pulse, first byte retained.
REQ-039 SHALL be verified with: reset asserted mid-shift -> all outputs 0 immediately; next byte 0x02 is decoded as bit-bang, giving o_tms=1.

Source files
------------

// File: rtl/blaster_cmd_decoder.sv
// blaster_cmd_decoder
// Decodes the USB-Blaster style byte stream coming from a UART receiver.
// Each byte is one of two things. A bit-bang byte drives TCK/TMS/TDI directly
// and can optionally read TDO back. A shift header is followed by N data bytes
// that are clocked out LSB first on TDI; TDO can be captured and returned.
// Responses go out through a one-entry valid/ready holding register.
module blaster_cmd_decoder #(
  parameter int TCK_HALF = 4
) (
  input  logic       i_Clock,
  input  logic       reset,
  input  logic       i_rdy,
  input  logic [7:0] i_byte,
  input  logic       i_tdo,
  output logic       o_tck,
  output logic       o_tms,
  output logic       o_tdi,
  output logic       o_tx_valid,
  output logic [7:0] o_tx_byte,
  input  logic       i_tx_ready,
  output logic       o_busy,
  output logic       o_err
);

  // The cycle counter runs 0..TCK_HALF-1 inside each TCK half-period.
  localparam int CNT_W = $clog2(TCK_HALF + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TCK_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SHIFT_WAIT = 2'd1,
    SHIFT_LOW  = 2'd2,
    SHIFT_HIGH = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic             tdo_meta_reg, tdo_sync_reg;
  logic             tck_reg, tck_next;
  logic             tms_reg, tms_next;
  logic             tdi_reg, tdi_next;
  logic [5:0]       remaining_reg, remaining_next;
  logic             read_reg, read_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [CNT_W-1:0] cycle_cnt_reg, cycle_cnt_next;
  logic [7:0]       data_reg, data_next;
  logic [7:0]       cap_reg, cap_next;
  logic             tx_valid_reg, tx_valid_next;
  logic [7:0]       tx_byte_reg, tx_byte_next;
  logic             err_reg, err_next;

  // Decode-side requests into the response register.
  logic             resp_push;
  logic [7:0]       resp_value;
  logic             resp_drop;
  logic             byte_drop;
  logic             handshake;
  logic [2:0]       bit_idx_inc;

  assign o_tck      = tck_reg;
  assign o_tms      = tms_reg;
  assign o_tdi      = tdi_reg;
  assign o_tx_valid = tx_valid_reg;
  assign o_tx_byte  = tx_byte_reg;
  assign o_err      = err_reg;
  assign o_busy     = (state_reg == SHIFT_LOW) || (state_reg == SHIFT_HIGH);

  assign handshake   = tx_valid_reg && i_tx_ready;
  assign bit_idx_inc = bit_idx_reg + 3'd1;

  // Two-flop synchroniser for the asynchronous TDO pin.
  always_ff @(posedge i_Clock or posedge reset) begin
    if (reset) begin
      tdo_meta_reg <= 1'b0;
      tdo_sync_reg <= 1'b0;
    end else begin
      tdo_meta_reg <= i_tdo;
      tdo_sync_reg <= tdo_meta_reg;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_Clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      tck_reg       <= 1'b0;
      tms_reg       <= 1'b0;
      tdi_reg       <= 1'b0;
      remaining_reg <= 6'd0;
      read_reg      <= 1'b0;
      bit_idx_reg   <= 3'd0;
      cycle_cnt_reg <= '0;
      data_reg      <= 8'd0;
      cap_reg       <= 8'd0;
      tx_valid_reg  <= 1'b0;
      tx_byte_reg   <= 8'd0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tck_reg       <= tck_next;
      tms_reg       <= tms_next;
      tdi_reg       <= tdi_next;
      remaining_reg <= remaining_next;
      read_reg      <= read_next;
      bit_idx_reg   <= bit_idx_next;
      cycle_cnt_reg <= cycle_cnt_next;
      data_reg      <= data_next;
      cap_reg       <= cap_next;
      tx_valid_reg  <= tx_valid_next;
      tx_byte_reg   <= tx_byte_next;
      err_reg       <= err_next;
    end
  end

  // Command decode and shift sequencing.
  always_comb begin
    state_next     = state_reg;
    tck_next       = tck_reg;
    tms_next       = tms_reg;
    tdi_next       = tdi_reg;
    remaining_next = remaining_reg;
    read_next      = read_reg;
    bit_idx_next   = bit_idx_reg;
    cycle_cnt_next = cycle_cnt_reg;
    data_next      = data_reg;
    cap_next       = cap_reg;
    resp_push      = 1'b0;
    resp_value     = 8'd0;
    byte_drop      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (i_rdy) begin
          if (!i_byte[7]) begin
            // Bit-bang: pins follow the byte, TDO is read back when b6 is set.
            tck_next = i_byte[0];
            tms_next = i_byte[1];
            tdi_next = i_byte[4];
            if (i_byte[6]) begin
              resp_push  = 1'b1;
              resp_value = {7'b0, tdo_sync_reg};
            end
          end else if (i_byte[5:0] != 6'd0) begin
            // Shift header; a zero count is silently ignored.
            remaining_next = i_byte[5:0];
            read_next      = i_byte[6];
            state_next     = SHIFT_WAIT;
          end
        end
      end

      SHIFT_WAIT: begin
        // The next byte is payload, never a command.
        if (i_rdy) begin
          data_next      = i_byte;
          bit_idx_next   = 3'd0;
          cycle_cnt_next = '0;
          tck_next       = 1'b0;
          tdi_next       = i_byte[0];
          state_next     = SHIFT_LOW;
        end
      end

      SHIFT_LOW: begin
        byte_drop = i_rdy;
        if (cycle_cnt_reg == CNT_LAST) begin
          // TDO is sampled at the very end of the low phase, just before TCK rises.
          cap_next[bit_idx_reg] = tdo_sync_reg;
          cycle_cnt_next        = '0;
          tck_next              = 1'b1;
          state_next            = SHIFT_HIGH;
        end else begin
          cycle_cnt_next = cycle_cnt_reg + CNT_ONE;
        end
      end

      SHIFT_HIGH: begin
        byte_drop = i_rdy;
        if (cycle_cnt_reg == CNT_LAST) begin
          cycle_cnt_next = '0;
          tck_next       = 1'b0;
          if (bit_idx_reg != 3'd7) begin
            bit_idx_next = bit_idx_inc;
            tdi_next     = data_reg[bit_idx_inc];
            state_next   = SHIFT_LOW;
          end else begin
            // Byte complete: return the captured TDO bits if reading.
            if (read_reg) begin
              resp_push  = 1'b1;
              resp_value = cap_reg;
            end
            remaining_next = remaining_reg - 6'd1;
            state_next     = (remaining_reg == 6'd1) ? IDLE : SHIFT_WAIT;
          end
        end else begin
          cycle_cnt_next = cycle_cnt_reg + CNT_ONE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One-entry response register; a push into a full, unaccepted slot is lost.
  always_comb begin
    tx_valid_next = tx_valid_reg;
    tx_byte_next  = tx_byte_reg;
    resp_drop     = 1'b0;
    if (resp_push) begin
      if (!tx_valid_reg || handshake) begin
        tx_valid_next = 1'b1;
        tx_byte_next  = resp_value;
      end else begin
        resp_drop = 1'b1;
      end
    end else if (handshake) begin
      tx_valid_next = 1'b0;
    end
    err_next = byte_drop || resp_drop;
  end

endmodule

// File: tb/tb_blaster_cmd_decoder.sv
// tb_blaster_cmd_decoder
// Directed stimulus with literal expectations, plus a timeline model of the
// decoder that a negedge process compares against the DUT every cycle.
module tb_blaster_cmd_decoder;

  localparam int TH   = 4;
  localparam int RING = 1024;

  logic       i_Clock;
  logic       reset;
  logic       i_rdy;
  logic [7:0] i_byte;
  logic       i_tdo;
  logic       o_tck;
  logic       o_tms;
  logic       o_tdi;
  logic       o_tx_valid;
  logic [7:0] o_tx_byte;
  logic       i_tx_ready;
  logic       o_busy;
  logic       o_err;

  logic       tdo_val;
  logic       loopback;

  int n_checks = 0;
  int n_errors = 0;

  assign i_tdo = loopback ? o_tdi : tdo_val;

  blaster_cmd_decoder #(.TCK_HALF(TH)) dut (
    .i_Clock    (i_Clock),
    .reset      (reset),
    .i_rdy      (i_rdy),
    .i_byte     (i_byte),
    .i_tdo      (i_tdo),
    .o_tck      (o_tck),
    .o_tms      (o_tms),
    .o_tdi      (o_tdi),
    .o_tx_valid (o_tx_valid),
    .o_tx_byte  (o_tx_byte),
    .i_tx_ready (i_tx_ready),
    .o_busy     (o_busy),
    .o_err      (o_err)
  );

  initial begin
    i_Clock = 1'b0;
    forever #5 i_Clock = ~i_Clock;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- TCK edge recorder ----------------
  int   rises = 0;
  logic tdi_hist [0:255];

  // Record TDI seen on each rising TCK edge.
  always @(posedge o_tck) begin
    tdi_hist[rises % 256] <= o_tdi;
    rises <= rises + 1;
  end

  // ---------------- model ----------------
  logic       in_rdy = 1'b0, in_tdo = 1'b0, in_txr = 1'b0;
  logic [7:0] in_byte = 8'd0;

  // Inputs are stable mid-cycle; this is what the DUT sees at the next edge.
  always @(negedge i_Clock) begin
    in_rdy  <= i_rdy;
    in_byte <= i_byte;
    in_tdo  <= i_tdo;
    in_txr  <= i_tx_ready;
  end

  logic       exp_tck = 0, exp_tms = 0, exp_tdi = 0, exp_busy = 0, exp_err = 0, exp_txv = 0;
  logic [7:0] exp_txb = 8'd0;
  int         now = 0;
  int         a_cyc = 0;
  int         left = 0;
  int         p;
  bit         active = 0, waiting = 0, rd = 0;
  logic [7:0] sdata = 8'd0;
  logic       d1 = 0, d2 = 0, seen;
  logic       seen_at [0:RING-1];
  bit         push, drop, hs;
  logic [7:0] pval;

  // Timeline model: a shift accepted at edge a occupies cycles a..a+16*TH-1,
  // half-period p=(n-a)/TH gives TCK=p odd and TDI=data[p/2]; bit k is read at edge a+(2k+1)*TH.
  initial begin
    forever begin
      @(posedge i_Clock or posedge reset);
      now++;
      if (reset) begin
        exp_tck = 0; exp_tms = 0; exp_tdi = 0; exp_busy = 0; exp_err = 0;
        exp_txv = 0; exp_txb = 8'd0;
        active = 0; waiting = 0; rd = 0; left = 0; d1 = 0; d2 = 0;
      end else begin
        seen = d2; d2 = d1; d1 = in_tdo;
        seen_at[now % RING] = seen;
        push = 0; drop = 0; pval = 8'd0;
        if (in_rdy) begin
          if (active) begin
            drop = 1;
          end else if (waiting) begin
            waiting = 0; active = 1; a_cyc = now; sdata = in_byte;
          end else if (!in_byte[7]) begin
            exp_tck = in_byte[0]; exp_tms = in_byte[1]; exp_tdi = in_byte[4];
            if (in_byte[6]) begin
              push = 1; pval = {7'b0, seen};
            end
          end else if (in_byte[5:0] != 6'd0) begin
            left = int'(in_byte[5:0]); rd = in_byte[6]; waiting = 1;
          end
        end
        if (active && now == a_cyc + 16 * TH) begin
          active = 0; exp_tck = 0;
          if (rd) begin
            push = 1;
            for (int k = 0; k < 8; k++) pval[k] = seen_at[(a_cyc + (2 * k + 1) * TH) % RING];
          end
          left--;
          waiting = (left != 0);
        end
        if (active) begin
          p = (now - a_cyc) / TH;
          exp_tck = p[0];
          exp_tdi = sdata[p[3:1]];
        end
        exp_busy = active;
        hs = exp_txv && in_txr;
        if (push) begin
          if (!exp_txv || hs) begin
            exp_txv = 1; exp_txb = pval;
          end else begin
            drop = 1;
          end
        end else if (hs) begin
          exp_txv = 0;
        end
        exp_err = drop;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge i_Clock) begin
    check("cyc_tck",  {7'b0, o_tck},      {7'b0, exp_tck});
    check("cyc_tms",  {7'b0, o_tms},      {7'b0, exp_tms});
    check("cyc_tdi",  {7'b0, o_tdi},      {7'b0, exp_tdi});
    check("cyc_busy", {7'b0, o_busy},     {7'b0, exp_busy});
    check("cyc_err",  {7'b0, o_err},      {7'b0, exp_err});
    check("cyc_txv",  {7'b0, o_tx_valid}, {7'b0, exp_txv});
    check("cyc_txb",  o_tx_byte,          exp_txb);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge i_Clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    i_rdy = 1'b1;
    i_byte = b;
    tick(1);
    i_rdy = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (o_busy && k < 500) begin
      tick(1);
      k++;
    end
    check(name, {7'b0, o_busy}, 8'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_tck"},  {7'b0, o_tck},      8'd0);
    check({name, "_tms"},  {7'b0, o_tms},      8'd0);
    check({name, "_tdi"},  {7'b0, o_tdi},      8'd0);
    check({name, "_txv"},  {7'b0, o_tx_valid}, 8'd0);
    check({name, "_txb"},  o_tx_byte,          8'd0);
    check({name, "_busy"}, {7'b0, o_busy},     8'd0);
    check({name, "_err"},  {7'b0, o_err},      8'd0);
  endtask

  task automatic finish_sim();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  endtask

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got time limit reached, expected completion");
    finish_sim();
  end

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    int r0;
    logic [7:0] seq;

    reset = 1'b1; i_rdy = 1'b0; i_byte = 8'd0; i_tx_ready = 1'b0;
    tdo_val = 1'b0; loopback = 1'b0;
    tick(3);
    check_all_zero("reset");
    $display("txn reset: released at %0t", $time);
    reset = 1'b0;
    tick(2);

    // Bit-bang 0x13: TCK=1 TMS=1 TDI=1, no response.
    send(8'h13);
    $display("txn bitbang 0x13 at %0t", $time);
    check("bb13_tck", {7'b0, o_tck}, 8'd1);
    check("bb13_tms", {7'b0, o_tms}, 8'd1);
    check("bb13_tdi", {7'b0, o_tdi}, 8'd1);
    tick(2);
    check("bb13_txv", {7'b0, o_tx_valid}, 8'd0);

    // Bit-bang 0x40 with TDO=1: response 0x01, held until accepted.
    tdo_val = 1'b1;
    tick(4);
    send(8'h40);
    $display("txn bitbang 0x40 read at %0t", $time);
    check("bb40_txv", {7'b0, o_tx_valid}, 8'd1);
    check("bb40_txb", o_tx_byte, 8'h01);
    check("bb40_tck", {7'b0, o_tck}, 8'd0);
    tick(5);
    check("bb40_hold_txv", {7'b0, o_tx_valid}, 8'd1);
    i_tx_ready = 1'b1;
    tick(1);
    i_tx_ready = 1'b0;
    check("bb40_after_hs_txv", {7'b0, o_tx_valid}, 8'd0);

    // Header 0xC1 + data 0xA5 with TDO looped to TDI.
    tdo_val = 1'b0;
    loopback = 1'b1;
    send(8'hC1);
    check("c1_wait_busy", {7'b0, o_busy}, 8'd0);
    r0 = rises;
    send(8'hA5);
    $display("txn shift read 0xC1/0xA5 at %0t", $time);
    k = 0;
    while (!o_tx_valid && k < 200) begin
      tick(1);
      k++;
    end
    check("a5_latency", k[7:0], 8'd64);
    check("a5_txb", o_tx_byte, 8'hA5);
    check("a5_pulses", 8'(rises - r0), 8'd8);
    for (int i = 0; i < 8; i++) seq[i] = tdi_hist[(r0 + i) % 256];
    check("a5_tdi_seq", seq, 8'hA5);
    i_tx_ready = 1'b1;
    tick(1);
    i_tx_ready = 1'b0;
    loopback = 1'b0;

    // Header 0x82 + two bytes: 16 pulses, no response, back to IDLE.
    r0 = rises;
    send(8'h82);
    send(8'h3C);
    wait_idle("x82_first_idle");
    tick(2);
    send(8'hC3);
    $display("txn shift write 0x82/0x3C,0xC3 at %0t", $time);
    wait_idle("x82_second_idle");
    check("x82_pulses", 8'(rises - r0), 8'd16);
    check("x82_txv", {7'b0, o_tx_valid}, 8'd0);
    send(8'h02);
    check("x82_idle_tms", {7'b0, o_tms}, 8'd1);

    // Byte arriving in SHIFT_HIGH is dropped with an error pulse.
    send(8'h81);
    send(8'h00);
    k = 0;
    while (!o_tck && k < 100) begin
      tick(1);
      k++;
    end
    check("drop_reach_high", {7'b0, o_tck}, 8'd1);
    send(8'h00);
    $display("txn dropped byte in SHIFT_HIGH at %0t", $time);
    check("drop_err", {7'b0, o_err}, 8'd1);
    check("drop_tms_kept", {7'b0, o_tms}, 8'd1);
    check("drop_tck_kept", {7'b0, o_tck}, 8'd1);
    tick(1);
    check("drop_err_clear", {7'b0, o_err}, 8'd0);
    wait_idle("drop_idle");
    send(8'h00);
    check("drop_then_idle_tms", {7'b0, o_tms}, 8'd0);

    // Second response while the first is pending: dropped, first retained.
    tdo_val = 1'b1;
    tick(4);
    send(8'h40);
    check("ovf_first_txb", o_tx_byte, 8'h01);
    tdo_val = 1'b0;
    tick(4);
    send(8'h40);
    $display("txn response overflow at %0t", $time);
    check("ovf_err", {7'b0, o_err}, 8'd1);
    check("ovf_txb_kept", o_tx_byte, 8'h01);
    check("ovf_txv", {7'b0, o_tx_valid}, 8'd1);
    tick(1);
    // Response queued on the handshake cycle replaces the old byte.
    i_tx_ready = 1'b1;
    send(8'h40);
    $display("txn response on handshake at %0t", $time);
    check("hsq_txv", {7'b0, o_tx_valid}, 8'd1);
    check("hsq_txb", o_tx_byte, 8'h00);
    check("hsq_err", {7'b0, o_err}, 8'd0);
    tick(1);
    i_tx_ready = 1'b0;
    check("hsq_drain_txv", {7'b0, o_tx_valid}, 8'd0);

    // Reset mid-shift aborts everything; next byte is decoded in IDLE.
    send(8'hC1);
    send(8'hFF);
    tick(10);
    check("rst_busy_before", {7'b0, o_busy}, 8'd1);
    reset = 1'b1;
    #1;
    $display("txn reset mid-shift at %0t", $time);
    check_all_zero("rst_mid");
    tick(2);
    reset = 1'b0;
    send(8'h02);
    check("rst_bb_tms", {7'b0, o_tms}, 8'd1);
    check("rst_bb_tck", {7'b0, o_tck}, 8'd0);
    check("rst_bb_busy", {7'b0, o_busy}, 8'd0);
    tick(70);
    check("rst_no_resp", {7'b0, o_tx_valid}, 8'd0);

    tick(2);
    finish_sim();
  end

endmodule
